mod_cfg_sequencer: RTL

- Configuration sequencer for the voice-transmitter modulation path.
- Holds shadow copies of AM modulation depth, AM sub-carrier frequency word and main carrier frequency word, written through a valid/ready config port.
- Applies them atomically on a commit, aligned to an internal sample tick.
- Glides the carrier frequency word to its new target in bounded steps, so the transmit DDS never jumps abruptly.
- Drives the depth, sub-carrier and carrier-base inputs of the AM modulator / carrier frequency-word adder.

---
 rtl/mod_cfg_sequencer_pkg.sv | 31 +++
 rtl/mod_cfg_sequencer_tick_gen.sv | 43 ++++
 rtl/mod_cfg_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mod_cfg_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mod_cfg_sequencer_pkg
// Shared definitions for the modulation configuration sequencer and the audio
// datapath top: config register addresses, sequencer FSM encoding and the
// power-on modulation settings.
// -----------------------------------------------------------------------------
package mod_cfg_sequencer_pkg;

  // Config port register map (address 3 is reserved and discarded).
  localparam logic [1:0] ADDR_DEEP    = 2'd0;
  localparam logic [1:0] ADDR_CENTER  = 2'd1;
  localparam logic [1:0] ADDR_CARRIER = 2'd2;

  // Power-on modulation settings.
  localparam logic [15:0] DEEP_DEFAULT    = 16'd32768;     // 50 % AM depth
  localparam logic [31:0] CENTER_DEFAULT  = 32'd858993;    // 10 kHz sub-carrier
  localparam logic [31:0] CARRIER_DEFAULT = 32'd416611827; // carrier base word

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TICK = 2'd1,
    ST_RAMP      = 2'd2
  } seq_state_e;

  // Unsigned distance between two frequency words, never wrapping.
  function automatic logic [31:0] abs_diff(input logic [31:0] a,
                                           input logic [31:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/mod_cfg_sequencer_tick_gen.sv
// -----------------------------------------------------------------------------
// mod_cfg_sequencer_tick_gen
// Free-running sample strobe. The counter runs 0..STROBE_DIV-1 from reset
// release; o_tick is high for exactly the cycle in which the counter holds
// STROBE_DIV-1.
//
// Ports:
//   clk     in  1  clock
//   rst_n   in  1  asynchronous active-low reset
//   o_tick  out 1  one-cycle registered strobe, period STROBE_DIV
// -----------------------------------------------------------------------------
module mod_cfg_sequencer_tick_gen #(
  parameter int unsigned STROBE_DIV = 250  // 2..65535
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);

  localparam logic [15:0] LAST = 16'(STROBE_DIV - 1);

  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic        r_tick;

  assign w_cnt_nxt = (r_cnt == LAST) ? 16'd0 : r_cnt + 16'd1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      // Registered tick that lines up with the counter holding LAST.
      r_tick <= (w_cnt_nxt == LAST);
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/mod_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// mod_cfg_sequencer
// Configuration sequencer for the voice-transmitter modulation path. Shadow
// registers for AM depth, AM sub-carrier word and carrier target word are
// written through a valid/ready port and applied atomically on the first
// sample tick after a commit. The carrier word then glides to its target by
// at most RAMP_STEP per tick, never overshooting or wrapping.
//
// Ports:
//   clk_in        in  1   system clock
//   RST           in  1   asynchronous active-low reset
//   cfg_valid     in  1   config write request
//   cfg_ready     out 1   write accepted when high together with cfg_valid
//   cfg_addr      in  2   0 depth, 1 sub-carrier, 2 carrier target, 3 reserved
//   cfg_data      in  32  write data (depth uses [15:0])
//   commit        in  1   single-cycle request to apply the shadows
//   module_deep   out 16  active AM depth
//   center_fre    out 32  active AM sub-carrier word
//   carrier_base  out 32  active carrier word (unsigned)
//   tick          out 1   one-cycle sample strobe
//   ramping       out 1   carrier glide in progress
// -----------------------------------------------------------------------------
module mod_cfg_sequencer
  import mod_cfg_sequencer_pkg::*;
#(
  parameter int unsigned STROBE_DIV  = 250,
  parameter logic [31:0] RAMP_STEP   = 32'd4295,
  parameter logic [15:0] DEEP_RST    = DEEP_DEFAULT,
  parameter logic [31:0] CENTER_RST  = CENTER_DEFAULT,
  parameter logic [31:0] CARRIER_RST = CARRIER_DEFAULT
) (
  input  logic        clk_in,
  input  logic        RST,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [1:0]  cfg_addr,
  input  logic [31:0] cfg_data,
  input  logic        commit,
  output logic [15:0] module_deep,
  output logic [31:0] center_fre,
  output logic [31:0] carrier_base,
  output logic        tick,
  output logic        ramping
);

  seq_state_e  r_state, w_state_nxt;

  logic [15:0] r_sh_deep;
  logic [31:0] r_sh_center;
  logic [31:0] r_sh_target;

  logic [15:0] r_deep,    w_deep_nxt;
  logic [31:0] r_center,  w_center_nxt;
  logic [31:0] r_carrier, w_carrier_nxt;
  logic        r_ready;
  logic        r_ramping;

  logic        w_tick;
  logic        w_wr_en;
  logic [31:0] w_diff;
  logic [31:0] w_step_carrier;

  mod_cfg_sequencer_tick_gen #(
    .STROBE_DIV(STROBE_DIV)
  ) u_tick_gen (
    .clk   (clk_in),
    .rst_n (RST),
    .o_tick(w_tick)
  );

  assign w_wr_en = cfg_valid & r_ready;

  // One glide step toward the target; only used when the distance exceeds
  // RAMP_STEP, so the add/subtract can neither overshoot nor wrap.
  assign w_diff         = abs_diff(r_sh_target, r_carrier);
  assign w_step_carrier = (r_sh_target > r_carrier) ? (r_carrier + RAMP_STEP)
                                                    : (r_carrier - RAMP_STEP);

  // Shadow registers: only written while idle, never touch active outputs.
  always_ff @(posedge clk_in or negedge RST) begin
    if (!RST) begin
      r_sh_deep   <= DEEP_RST;
      r_sh_center <= CENTER_RST;
      r_sh_target <= CARRIER_RST;
    end else if (w_wr_en) begin
      case (cfg_addr)
        ADDR_DEEP:    r_sh_deep   <= cfg_data[15:0];
        ADDR_CENTER:  r_sh_center <= cfg_data;
        ADDR_CARRIER: r_sh_target <= cfg_data;
        default:      ; // reserved address: accepted and discarded
      endcase
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_deep_nxt    = r_deep;
    w_center_nxt  = r_center;
    w_carrier_nxt = r_carrier;
    case (r_state)
      ST_IDLE: begin
        if (commit) w_state_nxt = ST_WAIT_TICK;
      end
      ST_WAIT_TICK: begin
        if (w_tick) begin
          w_deep_nxt   = r_sh_deep;
          w_center_nxt = r_sh_center;
          if ((r_carrier == r_sh_target) || (RAMP_STEP == 32'd0)) begin
            w_carrier_nxt = r_sh_target;
            w_state_nxt   = ST_IDLE;
          end else begin
            w_state_nxt   = ST_RAMP;
          end
        end
      end
      ST_RAMP: begin
        if (w_tick) begin
          if (w_diff <= RAMP_STEP) begin
            w_carrier_nxt = r_sh_target;
            w_state_nxt   = ST_IDLE;
          end else begin
            w_carrier_nxt = w_step_carrier;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge RST) begin
    if (!RST) begin
      r_state   <= ST_IDLE;
      r_deep    <= DEEP_RST;
      r_center  <= CENTER_RST;
      r_carrier <= CARRIER_RST;
      r_ready   <= 1'b1;
      r_ramping <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_deep    <= w_deep_nxt;
      r_center  <= w_center_nxt;
      r_carrier <= w_carrier_nxt;
      // Status flags are registered alongside the state they decode.
      r_ready   <= (w_state_nxt == ST_IDLE);
      r_ramping <= (w_state_nxt == ST_RAMP);
    end
  end

  assign cfg_ready    = r_ready;
  assign module_deep  = r_deep;
  assign center_fre   = r_center;
  assign carrier_base = r_carrier;
  assign tick         = w_tick;
  assign ramping      = r_ramping;

endmodule
